stack_seq: RTL and testbench

Multi-cycle sequencer for stack operations (PUSH, POP, CALL, RET, RTI, interrupt entry) in the 8-bit pipelined processor.
- Drives the register file's dec_sp/inc_sp controls for R3 (SP).
- Issues the stack data-memory accesses through the shared memory arbiter.
- Returns popped data to the register-file write mux, the PC, or the flags.
- Holds a single-level flag shadow for interrupt entry/return.

---
 rtl/stack_pkg.sv | 34 +++
 rtl/stack_seq_if.sv | 29 ++
 rtl/stack_seq.sv | 166 ++++++++++++++++
 tb/tb_stack_seq.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer: op-codes, FSM encoding and
// default stack geometry.
package stack_pkg;

    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_RTI  = 3'b101;
    localparam logic [2:0] OP_INTR = 3'b110;

    localparam logic [7:0] STACK_BASE_DEF  = 8'hFF;
    localparam logic [7:0] STACK_LIMIT_DEF = 8'h00;
    localparam logic [7:0] VEC_ADDR_DEF    = 8'h01;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StRdWait,
        StVecRd,
        StVecWait,
        StDone
    } state_e;

    function automatic logic is_push_op(input logic [2:0] op);
        return (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INTR);
    endfunction

    function automatic logic is_pop_op(input logic [2:0] op);
        return (op == OP_POP) || (op == OP_RET) || (op == OP_RTI);
    endfunction

endpackage

// File: rtl/stack_seq_if.sv
// Stack data-memory port toward the shared memory arbiter.
interface stack_seq_if;

    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_gnt;
    logic [7:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_gnt,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_gnt,
        output mem_rdata
    );

endinterface

// File: rtl/stack_seq.sv
// Multi-cycle stack sequencer: pushes, pops, calls, returns and interrupt entry/return,
// driving SP pulses, arbitrated stack accesses and register/PC/flag write-back.
module stack_seq
    import stack_pkg::*;
#(
    parameter logic [7:0] STACK_BASE  = STACK_BASE_DEF,
    parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEF,
    parameter logic [7:0] VEC_ADDR    = VEC_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_code,
    input  logic [1:0]  op_rd,
    input  logic [7:0]  op_data,
    input  logic [3:0]  flags_in,
    input  logic [7:0]  sp_in,
    output logic        dec_sp,
    output logic        inc_sp,
    stack_seq_if.master mem,
    output logic        rf_we,
    output logic [1:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic        pc_load,
    output logic [7:0]  pc_value,
    output logic        flags_load,
    output logic [3:0]  flags_out,
    output logic        done,
    output logic        err
);

    state_e     state_q, state_d;
    logic [2:0] op_q;
    logic [1:0] rd_q;
    logic [7:0] data_q;
    logic [7:0] sp_q;
    logic [3:0] shadow_q;
    logic       err_q;

    logic accept;
    logic accept_push;
    logic accept_pop;
    logic accept_err;

    assign accept      = (state_q == StIdle) && op_valid;
    assign accept_push = is_push_op(op_code);
    assign accept_pop  = is_pop_op(op_code);
    assign accept_err  = !(accept_push || accept_pop)
                         || (accept_push && (sp_in == STACK_LIMIT))
                         || (accept_pop && (sp_in == STACK_BASE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= 3'b000;
            rd_q     <= 2'b00;
            data_q   <= 8'h00;
            sp_q     <= 8'h00;
            shadow_q <= 4'h0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= op_code;
                rd_q   <= op_rd;
                data_q <= op_data;
                sp_q   <= sp_in;
                err_q  <= accept_err;
            end
            // A rejected interrupt leaves the shadow untouched.
            if (accept && (op_code == OP_INTR) && !accept_err) begin
                shadow_q <= flags_in;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        op_ready      = 1'b0;
        dec_sp        = 1'b0;
        inc_sp        = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = 8'h00;
        mem.mem_wdata = 8'h00;
        rf_we         = 1'b0;
        rf_waddr      = 2'b00;
        rf_wdata      = 8'h00;
        pc_load       = 1'b0;
        pc_value      = 8'h00;
        flags_load    = 1'b0;
        flags_out     = 4'h0;
        done          = 1'b0;
        err           = 1'b0;

        unique case (state_q)
            StIdle: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    if (accept_err) begin
                        state_d = StDone;
                    end else if (accept_push) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StWr: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = sp_q;
                mem.mem_wdata = data_q;
                if (mem.mem_gnt) begin
                    dec_sp  = 1'b1;
                    state_d = (op_q == OP_INTR) ? StVecRd : StDone;
                end
            end
            StRd: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = sp_q + 8'd1;
                if (mem.mem_gnt) begin
                    inc_sp  = 1'b1;
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (op_q == OP_POP) begin
                    rf_we    = 1'b1;
                    rf_waddr = rd_q;
                    rf_wdata = mem.mem_rdata;
                end else begin
                    pc_load  = 1'b1;
                    pc_value = mem.mem_rdata;
                    if (op_q == OP_RTI) begin
                        flags_load = 1'b1;
                        flags_out  = shadow_q;
                    end
                end
                state_d = StDone;
            end
            StVecRd: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = VEC_ADDR;
                if (mem.mem_gnt) begin
                    state_d = StVecWait;
                end
            end
            StVecWait: begin
                pc_load  = 1'b1;
                pc_value = mem.mem_rdata;
                state_d  = StDone;
            end
            StDone: begin
                done    = 1'b1;
                err     = err_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_stack_seq.sv
// Randomised bench for stack_seq: a transaction-level stack model predicts each op's
// memory, SP, write-back, PC and flag effects plus latency.
module tb_stack_seq;
    import stack_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       op_valid, op_ready;
    logic [2:0] op_code;
    logic [1:0] op_rd;
    logic [7:0] op_data;
    logic [3:0] flags_in;
    logic [7:0] sp_in;
    logic       dec_sp, inc_sp, rf_we, pc_load, flags_load, done, err;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata, pc_value;
    logic [3:0] flags_out;

    stack_seq_if mem_bus ();

    stack_seq dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_rd(op_rd), .op_data(op_data), .flags_in(flags_in),
        .sp_in(sp_in), .dec_sp(dec_sp), .inc_sp(inc_sp), .mem(mem_bus),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc_load(pc_load),
        .pc_value(pc_value), .flags_load(flags_load), .flags_out(flags_out),
        .done(done), .err(err)
    );

    // Environment: data memory behind the arbiter and the register file holding SP in R3.
    logic [7:0] env_mem [256];
    logic [7:0] env_regs [4];
    logic       env_clr, cfg_sp_we, cfg_mem_we, gnt;
    logic [7:0] cfg_sp, cfg_addr, cfg_data, rdata_q;

    assign mem_bus.mem_gnt   = gnt;
    assign mem_bus.mem_rdata = rdata_q;
    assign sp_in             = env_regs[3];

    always @(posedge clk) begin
        if (env_clr) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= 8'h00;
            for (int i = 0; i < 4; i++) env_regs[i] <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            if (mem_bus.mem_req && gnt) begin
                if (mem_bus.mem_we) env_mem[mem_bus.mem_addr] <= mem_bus.mem_wdata;
                else rdata_q <= env_mem[mem_bus.mem_addr];
            end
            if (dec_sp) env_regs[3] <= env_regs[3] - 8'd1;
            if (inc_sp) env_regs[3] <= env_regs[3] + 8'd1;
            if (rf_we) env_regs[rf_waddr] <= rf_wdata;
            if (cfg_sp_we) env_regs[3] <= cfg_sp;
            if (cfg_mem_we) env_mem[cfg_addr] <= cfg_data;
        end
    end

    // Reference model state.
    logic [7:0] m_mem [256];
    logic [7:0] m_regs [4];
    logic [3:0] m_shadow;

    int n_checks = 0;
    int n_fail = 0;
    bit rand_gnt = 1'b0;
    int hold_cnt = 0;

    // Observations of the most recent op.
    int         n_dec, n_inc, n_rf, n_pc, n_fl, n_req, stalls, lat;
    logic       obs_done, obs_err;
    logic [7:0] obs_wa, obs_wd, obs_ra, obs_rfd, obs_pcv;
    logic [1:0] obs_rfa;
    logic [3:0] obs_flv;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_sp(input logic [7:0] v);
        @(negedge clk);
        cfg_sp_we = 1'b1;
        cfg_sp = v;
        @(posedge clk);
        #1 cfg_sp_we = 1'b0;
        m_regs[3] = v;
    endtask

    task automatic set_mem(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_mem_we = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clk);
        #1 cfg_mem_we = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic run_op(input logic [2:0] code, input logic [1:0] rd, input logic [7:0] data,
                          input logic [3:0] flags);
        logic [7:0] sp0, ra, v, prev_addr, prev_wdata;
        logic       is_push, is_pop, e_err, e_wr, e_rf, e_pc, e_fl, prev_stall;
        logic [7:0] e_wa, e_wd, e_rfd, e_pcv;
        logic [1:0] e_rfa;
        logic [3:0] e_flv;
        int         e_dec, e_inc, e_lat;

        sp0 = m_regs[3];
        ra = sp0 + 8'd1;
        is_push = (code == OP_PUSH) || (code == OP_CALL) || (code == OP_INTR);
        is_pop = (code == OP_POP) || (code == OP_RET) || (code == OP_RTI);
        e_err = !(is_push || is_pop) || (is_push && sp0 == 8'h00) || (is_pop && sp0 == 8'hFF);
        {e_wr, e_rf, e_pc, e_fl} = 4'b0;
        e_wa = 8'h00; e_wd = 8'h00; e_rfa = 2'b00; e_rfd = 8'h00; e_pcv = 8'h00; e_flv = 4'h0;
        e_dec = 0; e_inc = 0; e_lat = 1;
        if (!e_err && is_push) begin
            e_wr = 1'b1; e_wa = sp0; e_wd = data; e_dec = 1; e_lat = 2;
            m_mem[sp0] = data;
            m_regs[3] = sp0 - 8'd1;
            if (code == OP_INTR) begin
                m_shadow = flags;
                e_pc = 1'b1; e_pcv = m_mem[8'h01]; e_lat = 4;
            end
        end else if (!e_err) begin
            e_inc = 1; e_lat = 3;
            m_regs[3] = ra;
            v = m_mem[ra];
            if (code == OP_POP) begin
                e_rf = 1'b1; e_rfa = rd; e_rfd = v;
                m_regs[rd] = v;
            end else begin
                e_pc = 1'b1; e_pcv = v;
                if (code == OP_RTI) begin
                    e_fl = 1'b1; e_flv = m_shadow;
                end
            end
        end

        @(negedge clk);
        check_eq("op_ready_idle", op_ready, 1'b1);
        op_valid = 1'b1; op_code = code; op_rd = rd; op_data = data; flags_in = flags;
        @(posedge clk);
        #1;
        // Scramble the request fields so only latched values can be used.
        op_valid = 1'b0; op_code = 3'($urandom); op_rd = 2'($urandom);
        op_data = 8'($urandom); flags_in = 4'($urandom);

        n_dec = 0; n_inc = 0; n_rf = 0; n_pc = 0; n_fl = 0; n_req = 0; stalls = 0; lat = 0;
        obs_done = 1'b0; obs_err = 1'b0; prev_stall = 1'b0; prev_addr = 8'h00;
        prev_wdata = 8'h00;
        for (int c = 0; c < 64 && !obs_done; c++) begin
            @(negedge clk);
            if (hold_cnt > 0) begin
                gnt = 1'b0;
                hold_cnt--;
            end else begin
                gnt = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            #1;
            lat++;
            check_eq("sp_excl", {dec_sp, inc_sp} == 2'b11, 1'b0);
            check_eq("rf_vs_sp", rf_we & (dec_sp | inc_sp), 1'b0);
            if (mem_bus.mem_req && prev_stall) begin
                check_eq("stall_addr", mem_bus.mem_addr, prev_addr);
                check_eq("stall_wdata", mem_bus.mem_wdata, prev_wdata);
            end
            if (mem_bus.mem_req) n_req++;
            if (mem_bus.mem_req && !gnt) stalls++;
            prev_stall = mem_bus.mem_req && !gnt;
            prev_addr = mem_bus.mem_addr;
            prev_wdata = mem_bus.mem_wdata;
            if (dec_sp) begin
                n_dec++;
                check_eq("dec_in_wr_gnt", mem_bus.mem_req & mem_bus.mem_we & gnt, 1'b1);
                obs_wa = mem_bus.mem_addr; obs_wd = mem_bus.mem_wdata;
            end
            if (inc_sp) begin
                n_inc++;
                check_eq("inc_in_rd_gnt", mem_bus.mem_req & ~mem_bus.mem_we & gnt, 1'b1);
                obs_ra = mem_bus.mem_addr;
            end
            if (rf_we) begin n_rf++; obs_rfa = rf_waddr; obs_rfd = rf_wdata; end
            if (pc_load) begin n_pc++; obs_pcv = pc_value; end
            if (flags_load) begin n_fl++; obs_flv = flags_out; end
            if (done) begin obs_done = 1'b1; obs_err = err; end
        end
        gnt = 1'b1;

        check_eq("done_seen", obs_done, 1'b1);
        check_eq("err", obs_err, e_err);
        check_eq("n_dec", n_dec, e_dec);
        check_eq("n_inc", n_inc, e_inc);
        if (e_wr) begin
            check_eq("wr_addr", obs_wa, e_wa);
            check_eq("wr_data", obs_wd, e_wd);
        end
        if (e_inc == 1) check_eq("rd_addr", obs_ra, ra);
        check_eq("n_rf", n_rf, e_rf);
        if (e_rf) begin
            check_eq("rf_waddr", obs_rfa, e_rfa);
            check_eq("rf_wdata", obs_rfd, e_rfd);
        end
        check_eq("n_pc", n_pc, e_pc);
        if (e_pc) check_eq("pc_value", obs_pcv, e_pcv);
        check_eq("n_flags", n_fl, e_fl);
        if (e_fl) check_eq("flags_out", obs_flv, e_flv);
        check_eq("latency", lat, e_lat + stalls);
        if (e_err) check_eq("err_no_req", n_req, 0);
        for (int i = 0; i < 4; i++) check_eq("regfile", env_regs[i], m_regs[i]);
        if (e_wr) check_eq("mem_word", env_mem[e_wa], m_mem[e_wa]);
    endtask

    initial begin
        logic [2:0] code;

        op_valid = 1'b0; op_code = 3'b000; op_rd = 2'b00; op_data = 8'h00; flags_in = 4'h0;
        gnt = 1'b1; env_clr = 1'b1; cfg_sp_we = 1'b0; cfg_mem_we = 1'b0;
        cfg_sp = 8'h00; cfg_addr = 8'h00; cfg_data = 8'h00;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_shadow = 4'h0;

        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_op_ready", op_ready, 1'b1);
        check_eq("rst_outputs", {mem_bus.mem_req, dec_sp, inc_sp, rf_we, pc_load, flags_load,
                                 done, err}, 8'h00);
        check_eq("rst_data", {mem_bus.mem_addr, pc_value, rf_wdata, flags_out}, 28'h0);
        env_clr = 1'b0;
        rst_n = 1'b1;

        // Directed PUSH at the empty stack.
        set_mem(8'h01, 8'h80);
        set_sp(8'hFF);
        run_op(OP_PUSH, 2'd0, 8'hA5, 4'h0);
        check_eq("push_wa", obs_wa, 8'hFF);
        check_eq("push_wd", obs_wd, 8'hA5);
        check_eq("push_lat", lat, 2);

        // Directed POP to R2.
        set_mem(8'hFF, 8'h3C);
        set_sp(8'hFE);
        run_op(OP_POP, 2'd2, 8'h00, 4'h0);
        check_eq("pop_ra", obs_ra, 8'hFF);
        check_eq("pop_rfd", obs_rfd, 8'h3C);
        check_eq("pop_r2", env_regs[2], 8'h3C);

        // Interrupt entry then return.
        set_sp(8'hFF);
        run_op(OP_INTR, 2'd0, 8'h40, 4'b1010);
        check_eq("intr_pc", obs_pcv, 8'h80);
        check_eq("intr_lat", lat, 4);
        run_op(OP_RTI, 2'd0, 8'h00, 4'h0);
        check_eq("rti_pc", obs_pcv, 8'h40);
        check_eq("rti_flags", obs_flv, 4'b1010);

        // Grant withheld for three cycles.
        hold_cnt = 3;
        run_op(OP_PUSH, 2'd0, 8'h5A, 4'h0);
        check_eq("hold_lat", lat, 5);

        // Error cases.
        set_sp(8'hFF);
        run_op(OP_POP, 2'd1, 8'h00, 4'h0);
        set_sp(8'h00);
        run_op(OP_PUSH, 2'd0, 8'h11, 4'h0);
        run_op(3'b111, 2'd0, 8'h22, 4'h0);
        run_op(3'b000, 2'd0, 8'h33, 4'h0);

        // Randomised traffic with random grant stalls.
        rand_gnt = 1'b1;
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 11))
                0: set_sp(8'hFF);
                1: set_sp(8'h00);
                2: set_sp(8'($urandom));
                3: set_mem(8'h01, 8'($urandom));
                default: ;
            endcase
            code = 3'($urandom);
            if (code == OP_INTR && m_regs[3] == 8'h00) set_sp(8'h80);
            run_op(code, 2'($urandom), 8'($urandom), 4'($urandom));
        end
        rand_gnt = 1'b0;

        // Reset in the middle of a read with the grant withheld.
        set_sp(8'hF0);
        run_op(OP_INTR, 2'd0, 8'h12, 4'b0110);
        set_sp(8'hFE);
        set_mem(8'hFF, 8'h77);
        @(negedge clk);
        gnt = 1'b0;
        op_valid = 1'b1; op_code = OP_POP; op_rd = 2'd1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        #1;
        check_eq("pre_rst_req", mem_bus.mem_req, 1'b1);
        check_eq("pre_rst_addr", mem_bus.mem_addr, 8'hFF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_outputs", {mem_bus.mem_req, dec_sp, inc_sp, rf_we, pc_load,
                                     flags_load, done, err}, 8'h00);
        check_eq("mid_rst_ready", op_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        gnt = 1'b1;
        m_shadow = 4'h0;
        @(negedge clk);
        #1;
        check_eq("post_rst_ready", op_ready, 1'b1);
        check_eq("post_rst_sp", env_regs[3], 8'hFE);
        check_eq("post_rst_r1", env_regs[1], m_regs[1]);
        run_op(OP_RTI, 2'd0, 8'h00, 4'h0);
        check_eq("rti_after_rst_pc", obs_pcv, 8'h77);
        check_eq("rti_after_rst_flags", obs_flv, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
